// File: rtl/bell_round_ctrl.sv
`default_nettype none
// ============================================================================
// bell_round_ctrl : bell card game sequencer (deal pacing, press arbitration,
//                   judge/score/lockout sequencing, win detection)
// Revision 1.0
// ============================================================================
module bell_round_ctrl #(
  parameter int REVEAL_CYCLES = 50_000_000,
  parameter int LOCK_CYCLES   = 25_000_000,
  parameter int WIN_MARGIN    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] keypad_in,
  input  logic       right,
  input  logic [8:0] scoreA,
  input  logic [8:0] scoreB,
  output logic       deal_req,
  output logic       turn,
  output logic [1:0] who,
  output logic       score_en,
  output logic [7:0] count,
  output logic       finish,
  output logic [1:0] lcd_sig
);

  localparam logic [3:0] c_key_a = 4'b0111;
  localparam logic [3:0] c_key_b = 4'b1001;
  localparam int c_tmax = (REVEAL_CYCLES > LOCK_CYCLES) ? REVEAL_CYCLES : LOCK_CYCLES;
  localparam int c_tw   = (c_tmax > 1) ? $clog2(c_tmax) : 1;
  localparam logic [c_tw-1:0] c_reveal_last = c_tw'(REVEAL_CYCLES - 1);
  localparam logic [c_tw-1:0] c_lock_last   = c_tw'(LOCK_CYCLES - 1);
  localparam logic [9:0]      c_margin      = 10'(WIN_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEAL  = 3'd1,
    S_SHOW  = 3'd2,
    S_JUDGE = 3'd3,
    S_SCORE = 3'd4,
    S_LOCK  = 3'd5,
    S_CHECK = 3'd6,
    S_OVER  = 3'd7
  } state_t;

  state_t          r_state;
  logic [3:0]      r_prev_key;
  logic [c_tw-1:0] r_timer;
  logic            r_right_q;

  logic       w_bell_a;
  logic       w_bell_b;
  logic [9:0] w_a_ext;
  logic [9:0] w_b_ext;
  logic       w_a_wins;
  logic       w_b_wins;

  // A bell is an edge only: a held key matches the previous sample and is ignored.
  assign w_bell_a = (keypad_in == c_key_a) && (r_prev_key != c_key_a);
  assign w_bell_b = (keypad_in == c_key_b) && (r_prev_key != c_key_b);

  // Zero-extend before adding the margin so the sum never wraps.
  assign w_a_ext  = {1'b0, scoreA};
  assign w_b_ext  = {1'b0, scoreB};
  assign w_a_wins = w_a_ext > (w_b_ext + c_margin);
  assign w_b_wins = w_b_ext > (w_a_ext + c_margin);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_prev_key <= 4'b0000;
      r_timer    <= '0;
      r_right_q  <= 1'b0;
      deal_req   <= 1'b0;
      turn       <= 1'b0;
      who        <= 2'b00;
      score_en   <= 1'b0;
      count      <= 8'd0;
      finish     <= 1'b0;
      lcd_sig    <= 2'b00;
    end else begin
      r_prev_key <= keypad_in;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            deal_req <= 1'b1;
            r_state  <= S_DEAL;
          end
        end
        S_DEAL: begin
          deal_req <= 1'b0;
          turn     <= ~turn;
          count    <= (count == 8'hFF) ? count : count + 8'd1;
          r_timer  <= '0;
          r_state  <= S_SHOW;
        end
        S_SHOW: begin
          // A press on the expiry cycle takes priority over the next deal.
          if (w_bell_a || w_bell_b) begin
            who     <= w_bell_a ? 2'b01 : 2'b10;
            r_state <= S_JUDGE;
          end else if (r_timer == c_reveal_last) begin
            deal_req <= 1'b1;
            r_state  <= S_DEAL;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_JUDGE: begin
          r_right_q <= right;
          score_en  <= 1'b1;
          finish    <= 1'b1;
          r_state   <= S_SCORE;
        end
        S_SCORE: begin
          score_en <= 1'b0;
          finish   <= 1'b0;
          if (r_right_q) begin
            count <= 8'd0;
          end
          r_timer <= '0;
          r_state <= S_LOCK;
        end
        S_LOCK: begin
          if (r_timer == c_lock_last) begin
            who     <= 2'b00;
            r_state <= S_CHECK;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_a_wins) begin
            lcd_sig <= 2'b01;
            r_state <= S_OVER;
          end else if (w_b_wins) begin
            lcd_sig <= 2'b10;
            r_state <= S_OVER;
          end else begin
            deal_req <= 1'b1;
            r_state  <= S_DEAL;
          end
        end
        S_OVER: begin
          if (start) begin
            lcd_sig <= 2'b00;
            count   <= 8'd0;
            turn    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
